// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N-input registered mux pipeline.
//   DefaultSize : default data width per operand
//   MaxInputs   : largest supported number of selectable inputs
//   sel_width() : select width for a given input count (never less than 1 bit)
package mux_pkg;

  localparam int unsigned DefaultSize = 32;
  localparam int unsigned MaxInputs   = 16;

  function automatic int unsigned sel_width(int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_n_input_pipe_if.sv
// Handshake bundle for mux_n_input_pipe.
//   Upstream side  : in_data (N_INPUTS x SIZE), sel, in_valid -> in_ready
//   Downstream side: out_data, out_err, out_valid -> out_ready
// master = producer/consumer environment, slave = the pipeline itself.
interface mux_n_input_pipe_if
  import mux_pkg::*;
#(
  parameter int unsigned SIZE     = DefaultSize,
  parameter int unsigned N_INPUTS = 3
);

  localparam int unsigned SEL_W = sel_width(N_INPUTS);

  logic [N_INPUTS-1:0][SIZE-1:0] in_data;
  logic [SEL_W-1:0]              sel;
  logic                          in_valid;
  logic                          in_ready;
  logic [SIZE-1:0]               out_data;
  logic                          out_err;
  logic                          out_valid;
  logic                          out_ready;

  modport master (
    output in_data, sel, in_valid, out_ready,
    input  in_ready, out_data, out_err, out_valid
  );

  modport slave (
    input  in_data, sel, in_valid, out_ready,
    output in_ready, out_data, out_err, out_valid
  );

endinterface

// File: rtl/skid_buffer.sv
// Two-entry valid/ready buffer: an output register plus one skid entry.
//   clk_i, rst_ni          : clock, synchronous active-low reset
//   in_valid_i/in_data_i   : upstream item, accepted when in_ready_o is high
//   in_ready_o             : high whenever the skid entry is free (registered only)
//   out_valid_o/out_data_o : registered output item
//   out_ready_i            : downstream consumes the output item
module skid_buffer #(
  parameter int unsigned Width = 33
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  input  logic [Width-1:0] in_data_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [Width-1:0] out_data_o,
  input  logic             out_ready_i
);

  logic [Width-1:0] out_data_q, out_data_d;
  logic [Width-1:0] skid_data_q, skid_data_d;
  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             accept;
  logic             drain;

  // Ready depends only on state, so there is no path from out_ready_i or in_valid_i.
  assign in_ready_o  = ~skid_valid_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

  always_comb begin
    accept       = in_valid_i & ~skid_valid_q;
    drain        = out_valid_q & out_ready_i;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;

    if (!out_valid_q || drain) begin
      if (skid_valid_q) begin
        // Oldest item lives in skid; it must leave first to keep order.
        out_data_d   = skid_data_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
        if (accept) begin
          skid_data_d  = in_data_i;
          skid_valid_d = 1'b1;
        end
      end else if (accept) begin
        out_data_d  = in_data_i;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      // Output stalled: park the new item.
      skid_data_d  = in_data_i;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      skid_data_q  <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
    end
  end

endmodule

// File: rtl/mux_n_input_pipe.sv
// Registered N-input mux with valid/ready flow control.
//   CLK, RESET_N : clock, synchronous active-low reset
//   bus (slave)  : in_data/sel/in_valid/in_ready upstream,
//                  out_data/out_err/out_valid/out_ready downstream
// An out-of-range sel yields in_data[0] tagged with out_err. N_INPUTS legal range 1..MaxInputs.
module mux_n_input_pipe
  import mux_pkg::*;
#(
  parameter int unsigned SIZE     = DefaultSize,
  parameter int unsigned N_INPUTS = 3
) (
  input logic                CLK,
  input logic                RESET_N,
  mux_n_input_pipe_if.slave  bus
);

  localparam int unsigned SEL_W = sel_width(N_INPUTS);

  logic [SIZE-1:0] sel_data;
  logic            sel_err;
  logic [SIZE:0]   skid_out;
  logic            skid_ready;
  logic            skid_out_valid;

  always_comb begin
    sel_data = bus.in_data[0];
    sel_err  = 1'b0;
    // With a single input sel is don't-care and no error is possible.
    if (N_INPUTS > 1) begin
      sel_err = 1'b1;
      for (int i = 0; i < int'(N_INPUTS); i++) begin
        if (int'(bus.sel) == i) begin
          sel_data = bus.in_data[i];
          sel_err  = 1'b0;
        end
      end
    end
  end

  skid_buffer #(
    .Width (SIZE + 1)
  ) u_skid (
    .clk_i       (CLK),
    .rst_ni      (RESET_N),
    .in_valid_i  (bus.in_valid),
    .in_data_i   ({sel_err, sel_data}),
    .in_ready_o  (skid_ready),
    .out_valid_o (skid_out_valid),
    .out_data_o  (skid_out),
    .out_ready_i (bus.out_ready)
  );

  // Ready is forced high while reset is asserted; state is cleared on that edge anyway.
  assign bus.in_ready  = skid_ready | ~RESET_N;
  assign bus.out_valid = skid_out_valid;
  assign bus.out_data  = skid_out[SIZE-1:0];
  assign bus.out_err   = skid_out[SIZE];

endmodule

// File: tb/tb_mux_n_input_pipe.sv
module tb_mux_n_input_pipe;

  localparam int unsigned SizeA = 32;
  localparam int unsigned NA    = 3;
  localparam int unsigned SizeB = 8;
  localparam int unsigned NB    = 5;

  localparam logic [31:0] ValA = 32'hAAAA_0001;
  localparam logic [31:0] ValB = 32'hBBBB_0002;
  localparam logic [31:0] ValC = 32'hCCCC_0003;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mux_n_input_pipe_if #(.SIZE(SizeA), .N_INPUTS(NA)) bus_a ();
  mux_n_input_pipe_if #(.SIZE(SizeB), .N_INPUTS(NB)) bus_b ();

  mux_n_input_pipe #(.SIZE(SizeA), .N_INPUTS(NA)) dut_a (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus_a.slave)
  );

  mux_n_input_pipe #(.SIZE(SizeB), .N_INPUTS(NB)) dut_b (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus_b.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_a    = 0;
  int cnt_b    = 0;

  logic [SizeA:0] q_a[$];
  logic [SizeB:0] q_b[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [SizeA:0] model_a(input logic [1:0] s,
                                             input logic [NA-1:0][SizeA-1:0] d);
    case (s)
      2'd0:    return {1'b0, d[0]};
      2'd1:    return {1'b0, d[1]};
      2'd2:    return {1'b0, d[2]};
      default: return {1'b1, d[0]};
    endcase
  endfunction

  function automatic logic [SizeB:0] model_b(input logic [2:0] s,
                                             input logic [NB-1:0][SizeB-1:0] d);
    case (s)
      3'd0:    return {1'b0, d[0]};
      3'd1:    return {1'b0, d[1]};
      3'd2:    return {1'b0, d[2]};
      3'd3:    return {1'b0, d[3]};
      3'd4:    return {1'b0, d[4]};
      default: return {1'b1, d[0]};
    endcase
  endfunction

  // Scoreboards: compare drained items first, then record newly accepted ones.
  always @(negedge clk) begin
    logic [SizeA:0] ea;
    logic [SizeB:0] eb;
    if (!rst_n) begin
      q_a.delete();
      q_b.delete();
    end else begin
      if (bus_a.out_valid && bus_a.out_ready) begin
        if (q_a.size() == 0) begin
          check("a_extra_output", 64'(bus_a.out_valid), 64'd0);
        end else begin
          ea = q_a.pop_front();
          check("a_sb_data", 64'(bus_a.out_data), 64'(ea[SizeA-1:0]));
          check("a_sb_err", 64'(bus_a.out_err), 64'(ea[SizeA]));
          cnt_a++;
        end
      end
      if (bus_a.in_valid && bus_a.in_ready) q_a.push_back(model_a(bus_a.sel, bus_a.in_data));

      if (bus_b.out_valid && bus_b.out_ready) begin
        if (q_b.size() == 0) begin
          check("b_extra_output", 64'(bus_b.out_valid), 64'd0);
        end else begin
          eb = q_b.pop_front();
          check("b_sb_data", 64'(bus_b.out_data), 64'(eb[SizeB-1:0]));
          check("b_sb_err", 64'(bus_b.out_err), 64'(eb[SizeB]));
          cnt_b++;
        end
      end
      if (bus_b.in_valid && bus_b.in_ready) q_b.push_back(model_b(bus_b.sel, bus_b.in_data));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_abc();
    bus_a.in_data[0] = ValA;
    bus_a.in_data[1] = ValB;
    bus_a.in_data[2] = ValC;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    rst_n           = 1'b0;
    bus_a.in_data   = '0;
    bus_a.sel       = '0;
    bus_a.in_valid  = 1'b0;
    bus_a.out_ready = 1'b0;
    bus_b.in_data   = '0;
    bus_b.sel       = '0;
    bus_b.in_valid  = 1'b0;
    bus_b.out_ready = 1'b0;

    // Reset state
    step();
    step();
    check("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus_a.in_ready), 64'd1);
    check("rst_out_data", 64'(bus_a.out_data), 64'd0);
    check("rst_out_err", 64'(bus_a.out_err), 64'd0);
    rst_n = 1'b1;
    step();
    check("post_rst_out_valid", 64'(bus_a.out_valid), 64'd0);
    check("post_rst_in_ready", 64'(bus_a.in_ready), 64'd1);

    // Select input 2 with one-cycle latency
    set_abc();
    bus_a.sel       = 2'd2;
    bus_a.in_valid  = 1'b1;
    bus_a.out_ready = 1'b1;
    step();
    bus_a.in_valid = 1'b0;
    check("sel2_valid", 64'(bus_a.out_valid), 64'd1);
    check("sel2_data", 64'(bus_a.out_data), 64'(ValC));
    check("sel2_err", 64'(bus_a.out_err), 64'd0);
    step();
    check("sel2_drained", 64'(bus_a.out_valid), 64'd0);

    // Out-of-range select falls back to input 0 with err
    bus_a.in_data[0] = 32'h11;
    bus_a.sel        = 2'd3;
    bus_a.in_valid   = 1'b1;
    step();
    bus_a.in_valid = 1'b0;
    check("oor_data", 64'(bus_a.out_data), 64'h11);
    check("oor_err", 64'(bus_a.out_err), 64'd1);
    step();

    // Backpressure: A held, B in skid, C waits
    set_abc();
    c0              = cnt_a;
    bus_a.sel       = 2'd0;
    bus_a.in_valid  = 1'b1;
    bus_a.out_ready = 1'b1;
    step();
    bus_a.out_ready = 1'b0;
    bus_a.sel       = 2'd1;
    step();
    check("bp_in_ready_low", 64'(bus_a.in_ready), 64'd0);
    check("bp_hold_a", 64'(bus_a.out_data), 64'(ValA));
    bus_a.sel = 2'd2;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_stall_data", 64'(bus_a.out_data), 64'(ValA));
      check("bp_stall_valid", 64'(bus_a.out_valid), 64'd1);
      check("bp_stall_ready", 64'(bus_a.in_ready), 64'd0);
    end
    bus_a.out_ready = 1'b1;
    step();
    check("bp_then_b", 64'(bus_a.out_data), 64'(ValB));
    step();
    bus_a.in_valid = 1'b0;
    check("bp_then_c", 64'(bus_a.out_data), 64'(ValC));
    step();
    check("bp_empty", 64'(bus_a.out_valid), 64'd0);
    check("bp_count", 64'(cnt_a - c0), 64'd3);

    // Full throughput stream of 8 items
    c0 = cnt_a;
    bus_a.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus_a.sel = 2'(i % 3);
      for (int k = 0; k < int'(NA); k++) bus_a.in_data[k] = $urandom;
      step();
      check("stream_valid", 64'(bus_a.out_valid), 64'd1);
    end
    bus_a.in_valid = 1'b0;
    step();
    check("stream_count", 64'(cnt_a - c0), 64'd8);
    check("stream_empty", 64'(bus_a.out_valid), 64'd0);

    // Reset with two items buffered
    bus_a.out_ready = 1'b0;
    bus_a.in_valid  = 1'b1;
    bus_a.sel       = 2'd1;
    step();
    step();
    check("pre_rst_full", 64'(bus_a.in_ready), 64'd0);
    bus_a.in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    check("mid_rst_out_valid", 64'(bus_a.out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(bus_a.in_ready), 64'd1);
    check("mid_rst_out_data", 64'(bus_a.out_data), 64'd0);
    rst_n = 1'b1;
    step();
    check("rel_out_valid", 64'(bus_a.out_valid), 64'd0);
    check("rel_in_ready", 64'(bus_a.in_ready), 64'd1);

    // Random traffic on the 5-input, 8-bit instance
    for (int i = 0; i < 300; i++) begin
      bus_b.in_valid  = ($urandom_range(0, 3) != 0);
      bus_b.sel       = 3'($urandom_range(0, 7));
      bus_b.out_ready = ($urandom_range(0, 2) != 0);
      for (int k = 0; k < int'(NB); k++) bus_b.in_data[k] = 8'($urandom);
      step();
    end
    bus_b.in_valid  = 1'b0;
    bus_b.out_ready = 1'b1;
    for (int i = 0; i < 20 && q_b.size() != 0; i++) step();
    step();
    check("b_drained", 64'(q_b.size()), 64'd0);
    check("b_out_idle", 64'(bus_b.out_valid), 64'd0);
    check("b_traffic_seen", 64'(cnt_b > 50), 64'd1);
    check("a_drained", 64'(q_a.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
